pmem_line_responder: RTL

//  Responder end of the 256-bit line pmem interface driven by the cache hierarchy's L2 (pmem_read/pmem_write/pmem_resp).

---
 rtl/pmem_line_responder_pkg.sv | 25 ++
 rtl/pmem_line_responder_line_ram.sv | 25 ++
 rtl/pmem_line_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pmem_line_responder_pkg.sv
// rtl/pmem_line_responder_pkg.sv - shared types and defaults for the pmem line responder
package pmem_line_responder_pkg;

   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 256;
   localparam int S_DEPTH  = 8;

   typedef logic [S_LINE-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } pmem_state_e;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } pmem_op_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pmem_line_responder_line_ram.sv
// rtl/pmem_line_responder_line_ram.sv - single-port line storage, sync write, registered read, no reset
module pmem_line_responder_line_ram #(
   parameter int WIDTH      = 256,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic                  i_re,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [WIDTH-1:0]      i_wdata,
   output logic [WIDTH-1:0]      o_rdata
);

   logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
   logic [WIDTH-1:0] r_rdata;

   // Read register only loads on a read, so it holds the last read line indefinitely.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_line_responder.sv
// rtl/pmem_line_responder.sv - responder for the 256-bit line pmem interface with fixed latency
module pmem_line_responder
   import pmem_line_responder_pkg::*;
#(
   parameter int s_offset      = S_OFFSET,
   parameter int s_line        = S_LINE,
   parameter int s_depth       = S_DEPTH,
   parameter int READ_LATENCY  = 10,
   parameter int WRITE_LATENCY = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pmem_read,
   input  logic              pmem_write,
   input  logic [31:0]       pmem_address,
   input  logic [s_line-1:0] pmem_wdata,
   output logic [s_line-1:0] pmem_rdata,
   output logic              pmem_resp,
   output logic              pmem_error
);

   localparam int CNT_W = $clog2(max2(READ_LATENCY, WRITE_LATENCY) + 1);

   pmem_state_e          r_state, w_next;
   pmem_op_e             r_op;
   logic [s_depth-1:0]   r_idx;
   logic [31-s_offset:0] r_tag;
   logic [s_line-1:0]    r_wdata;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_error;
   logic                 r_have_rdata;

   logic                 w_req;
   pmem_op_e             w_in_op;
   logic [s_depth-1:0]   w_in_idx;
   logic [CNT_W-1:0]     w_lat_m1;
   logic                 w_busy_viol;
   logic                 w_ram_we;
   logic                 w_ram_re;
   logic [s_depth-1:0]   w_ram_addr;
   logic [s_line-1:0]    w_ram_rdata;

   assign w_req    = pmem_read | pmem_write;
   assign w_in_op  = pmem_write ? OP_WRITE : OP_READ;
   assign w_in_idx = pmem_address[s_offset+s_depth-1:s_offset];
   assign w_lat_m1 = (w_in_op == OP_WRITE) ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);

   // The initiator must hold the same request through BUSY; anything else is flagged.
   assign w_busy_viol = (r_state == BUSY) &&
                        (!w_req || (w_in_op != r_op) || (pmem_address[31:s_offset] != r_tag));

   always_comb begin
      w_next   = r_state;
      w_ram_re = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_next   = (w_lat_m1 == '0) ? RESP : BUSY;
               w_ram_re = (w_lat_m1 == '0) && (w_in_op == OP_READ);
            end
         end
         BUSY: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next   = RESP;
               w_ram_re = (r_op == OP_READ);
            end
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_ram_we   = (r_state == RESP) && (r_op == OP_WRITE);
   assign w_ram_addr = (r_state == IDLE) ? w_in_idx : r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_op         <= OP_READ;
         r_idx        <= '0;
         r_tag        <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_error      <= 1'b0;
         r_have_rdata <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_req) begin
            r_op    <= w_in_op;
            r_idx   <= w_in_idx;
            r_tag   <= pmem_address[31:s_offset];
            r_wdata <= pmem_wdata;
            r_cnt   <= w_lat_m1;
            if (pmem_read && pmem_write) r_error <= 1'b1;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_busy_viol) r_error <= 1'b1;
         if (w_ram_re) r_have_rdata <= 1'b1;
      end
   end

   pmem_line_responder_line_ram #(
      .WIDTH      (s_line),
      .DEPTH_LOG2 (s_depth)
   ) u_line_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_re    (w_ram_re),
      .i_addr  (w_ram_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_ram_rdata)
   );

   // Storage is not reset, so the output is masked until the first read completes.
   assign pmem_rdata = r_have_rdata ? w_ram_rdata : '0;
   assign pmem_resp  = (r_state == RESP);
   assign pmem_error = r_error;

endmodule
